// File: rtl/pixel_sink_fifo_if.sv
// pixel_sink_fifo_if: pixel hand-off between the last pipeline stage, the
// sink FIFO and the downstream consumer.
// slave  = the FIFO side, master = the pipeline/consumer (or bench) side.
// When PIXEL_SINK_STATS_EN is defined the bundle also carries pix_count.
interface pixel_sink_fifo_if #(
  parameter int DEPTH = 4
);
  typedef logic [7:0] color_t;

  color_t                   color_in;
  logic                     color_in_valid;
  logic                     datapath_ready;
  logic                     flush;
  color_t                   color_out;
  logic                     color_out_valid;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   fill_level;
`ifdef PIXEL_SINK_STATS_EN
  logic [15:0]              pix_count;

  modport slave (
    input  color_in, color_in_valid, flush, out_ready,
    output datapath_ready, color_out, color_out_valid, fill_level, pix_count
  );

  modport master (
    output color_in, color_in_valid, flush, out_ready,
    input  datapath_ready, color_out, color_out_valid, fill_level, pix_count
  );
`else
  modport slave (
    input  color_in, color_in_valid, flush, out_ready,
    output datapath_ready, color_out, color_out_valid, fill_level
  );

  modport master (
    output color_in, color_in_valid, flush, out_ready,
    input  datapath_ready, color_out, color_out_valid, fill_level
  );
`endif
endinterface

// File: rtl/pixel_sink_fifo.sv
// pixel_sink_fifo: output buffer at the tail of the pixel pipeline.
// The buffer absorbs pixels while the downstream consumer stalls and drives
// the pipe-wide datapath_ready. Every output is taken straight from a
// register, so nothing downstream sees a combinational path from out_ready
// or color_in_valid. The head pixel is kept in its own register (head_r),
// which is loaded with the pixel that will sit at the head after each edge.
// Optional build macro: PIXEL_SINK_STATS_EN adds the pix_count pop counter.

// Consistency checker for the FIFO bookkeeping registers.
module pixel_sink_fifo_chk #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             resetN,
  input logic [CNT_W-1:0] count,
  input logic [PTR_W-1:0] wr_ptr,
  input logic [PTR_W-1:0] rd_ptr,
  input logic             ready,
  input logic             valid
);
  a_count_range: assert property (@(posedge clk) disable iff (!resetN)
    count <= CNT_W'(DEPTH));
  a_ready_matches_count: assert property (@(posedge clk) disable iff (!resetN)
    ready == (count < CNT_W'(DEPTH)));
  a_valid_matches_count: assert property (@(posedge clk) disable iff (!resetN)
    valid == (count != {CNT_W{1'b0}}));
  a_ptr_distance: assert property (@(posedge clk) disable iff (!resetN)
    ((int'(rd_ptr) + int'(count)) % DEPTH) == int'(wr_ptr));
endmodule

module pixel_sink_fifo #(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               resetN,
  pixel_sink_fifo_if.slave  bus
);
  typedef logic [7:0] color_t;

  localparam int     PTR_W     = $clog2(DEPTH);
  localparam int     CNT_W     = $clog2(DEPTH) + 1;
  localparam color_t MIN_COLOR = 8'h00;

  color_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               ready_r;
  logic               valid_r;
  color_t             head_r;

  logic               push_s;
  logic               pop_s;
  logic [PTR_W-1:0]   wr_ptr_inc_s;
  logic [PTR_W-1:0]   rd_ptr_inc_s;
  logic [PTR_W-1:0]   wr_ptr_nxt_s;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [CNT_W-1:0]   count_nxt_s;
  color_t             head_nxt_s;

  // A held stage output during a stall is not re-captured because ready_r
  // already reflects the stall; an empty buffer never pops since valid_r is 0.
  assign push_s = bus.color_in_valid & ready_r;
  assign pop_s  = valid_r & bus.out_ready;

  // Next-state computation for pointers, occupancy and the head register.
  always_comb begin
    wr_ptr_inc_s = (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
    rd_ptr_inc_s = (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    head_nxt_s   = head_r;
    if (bus.flush) begin
      // Flush wins over any push or pop presented in the same cycle.
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
      head_nxt_s   = MIN_COLOR;
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_inc_s;
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_inc_s;
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      if (count_nxt_s == {CNT_W{1'b0}}) begin
        head_nxt_s = MIN_COLOR;
      end else if (count_r == {CNT_W{1'b0}}) begin
        // Empty buffer receiving a pixel: it becomes the head immediately.
        head_nxt_s = bus.color_in;
      end else if (pop_s) begin
        // With one entry left the only survivor is the pixel being pushed;
        // otherwise the next stored entry moves up to the head.
        if (count_r == CNT_W'(1)) begin
          head_nxt_s = bus.color_in;
        end else begin
          head_nxt_s = mem_r[rd_ptr_inc_s];
        end
      end else begin
        head_nxt_s = head_r;
      end
    end
  end

  // Bookkeeping and output registers; ready is reloaded every cycle from the
  // occupancy that will hold after this edge.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ready_r  <= 1'b1;
      valid_r  <= 1'b0;
      head_r   <= MIN_COLOR;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ready_r  <= (count_nxt_s < CNT_W'(DEPTH));
      valid_r  <= (count_nxt_s != {CNT_W{1'b0}});
      head_r   <= head_nxt_s;
    end
  end

  // Pixel storage; deliberately left out of reset, contents are only read
  // at positions the pointers mark as occupied.
  always_ff @(posedge clk) begin
    if (push_s && !bus.flush) begin
      mem_r[wr_ptr_r] <= bus.color_in;
    end
  end

`ifdef PIXEL_SINK_STATS_EN
  logic [15:0] pix_count_r;

  // Pop counter since reset or flush; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pix_count_r <= 16'h0000;
    end else if (bus.flush) begin
      pix_count_r <= 16'h0000;
    end else if (pop_s) begin
      pix_count_r <= pix_count_r + 16'h0001;
    end
  end

  assign bus.pix_count = pix_count_r;
`endif

  assign bus.datapath_ready  = ready_r;
  assign bus.color_out_valid = valid_r;
  assign bus.color_out       = head_r;
  assign bus.fill_level      = count_r;

  pixel_sink_fifo_chk #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk    (clk),
    .resetN (resetN),
    .count  (count_r),
    .wr_ptr (wr_ptr_r),
    .rd_ptr (rd_ptr_r),
    .ready  (ready_r),
    .valid  (valid_r)
  );
endmodule

// File: tb/tb_pixel_sink_fifo.sv
// tb_pixel_sink_fifo: scoreboard bench. The stimulus process keeps an
// abstract model (occupancy counter, pop counter) and pushes every accepted
// pixel into exp_q; a separate monitor pops exp_q whenever the DUT hands a
// pixel to the consumer and compares the data.
module tb_pixel_sink_fifo;
  localparam int DEPTH = 4;
  localparam logic [7:0] MIN_COLOR = 8'h00;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  pixel_sink_fifo_if #(.DEPTH(DEPTH)) bus ();

  pixel_sink_fifo #(.DEPTH(DEPTH)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         mdl_cnt = 0;
  logic [15:0] mdl_pops = 16'h0000;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Outputs reflect the state after the previous edge; compare to the model.
  task automatic status(input string tag);
    check({tag, ".fill_level"}, int'(bus.fill_level), mdl_cnt);
    check({tag, ".datapath_ready"}, int'(bus.datapath_ready), (mdl_cnt < DEPTH) ? 1 : 0);
    check({tag, ".color_out_valid"}, int'(bus.color_out_valid), (mdl_cnt != 0) ? 1 : 0);
    if (mdl_cnt == 0) begin
      check({tag, ".color_out_min"}, int'(bus.color_out), int'(MIN_COLOR));
    end
`ifdef PIXEL_SINK_STATS_EN
    check({tag, ".pix_count"}, int'(bus.pix_count), int'(mdl_pops));
`endif
  endtask

  // One clock of stimulus: check status, drive inputs, advance the model.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit f);
    bit push;
    bit pop;
    @(negedge clk);
    status("cyc");
    bus.color_in_valid = v;
    bus.color_in       = d;
    bus.out_ready      = r;
    bus.flush          = f;
    if (f) begin
      exp_q.delete();
      mdl_cnt  = 0;
      mdl_pops = 16'h0000;
    end else begin
      push = v && (mdl_cnt < DEPTH);
      pop  = r && (mdl_cnt > 0);
      if (push) exp_q.push_back(d);
      mdl_cnt = mdl_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
      if (pop) mdl_pops = mdl_pops + 16'h0001;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN             = 1'b0;
    bus.color_in_valid = 1'b0;
    bus.color_in       = 8'h00;
    bus.out_ready      = 1'b0;
    bus.flush          = 1'b0;
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_pops = 16'h0000;
    #1;
    status("rst");
    #2;
    resetN = 1'b1;
  endtask

  // Monitor: whenever the DUT presents a pixel that is being accepted,
  // the oldest expected pixel must be on color_out.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (resetN && !bus.flush && bus.color_out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected actual=%0d required=none", bus.color_out);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", int'(bus.color_out), int'(e));
        end
      end
    end
  end

  initial begin
    bus.color_in_valid = 1'b0;
    bus.color_in       = 8'h00;
    bus.out_ready      = 1'b0;
    bus.flush          = 1'b0;
    do_reset();

    // Single pixel through an always-ready consumer.
    cycle(1'b1, 8'h10, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Fill to full with the consumer stalled, then hold 0x05 on the input.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h05, 1'b0, 1'b0);
    // One pop while full, then 0x05 is taken exactly once.
    cycle(1'b1, 8'h05, 1'b1, 1'b0);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push and pop at count 2.
    cycle(1'b1, 8'hA1, 1'b0, 1'b0);
    cycle(1'b1, 8'hA2, 1'b0, 1'b0);
    cycle(1'b1, 8'hA3, 1'b1, 1'b0);
    cycle(1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush at count 3 together with a push and a pop.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hBF, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset in the middle of traffic at count 3, then push right away.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'hD7, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 8'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
    end

`ifdef PIXEL_SINK_STATS_EN
    // Counter wrap: 65537 pops after a flush leave pix_count at 1.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 65538; i++) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("pix_count_wrap", int'(bus.pix_count), 1);
`endif

    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("drained_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_sink_fifo.md
PIXEL_SINK_FIFO -- requirements
Module: pixel_sink_fifo

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of 2 in 2..64.
REQ-002 Port clk  input  1  clock; all state on rising edge.
REQ-003 Port resetN  input  1  reset, asynchronous, active-low.
REQ-004 Port color_in  input  color_t (8)  pixel from last pipeline stage.
REQ-005 Port color_in_valid  input  1  color_in carries a pixel.
REQ-006 Port datapath_ready  output  1  pipe-wide advance/stall; 0 freezes every stage.
REQ-007 Port flush  input  1  synchronous clear of buffer contents.
REQ-008 Port color_out  output  color_t (8)  head-of-FIFO pixel.
REQ-009 Port color_out_valid  output  1  color_out holds a pixel.
REQ-010 Port out_ready  input  1  downstream consumer accepts color_out this cycle.
REQ-011 Port fill_level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.

Function
REQ-012 push = color_in_valid & datapath_ready; pixel written only on push, so a held stage output during stall is never captured twice.
REQ-013 pop = color_out_valid & out_ready; head entry removed on pop.
REQ-014 count_next = count + push - pop; simultaneous push and pop leave count unchanged.
REQ-015 datapath_ready SHALL be a register loaded each cycle with (count_next < DEPTH); no combinational path from out_ready or color_in_valid.
REQ-016 Push when count == DEPTH is impossible by REQ-015; no overflow or data loss.
REQ-017 Write/read pointers SHALL wrap from DEPTH-1 to 0.
REQ-018 color_out_valid = (count != 0), driven from registers only.
REQ-019 color_out = mem[rd_ptr] when color_out_valid = 1; MIN_COLOR when color_out_valid = 0.
REQ-020 Latency: pixel pushed at edge N into empty FIFO appears on color_out with color_out_valid = 1 in cycle after edge N.
REQ-021 Ordering strictly FIFO; data unmodified.
REQ-022 Full with pop: count DEPTH -> DEPTH-1, datapath_ready rises after the same edge.
REQ-023 Empty: out_ready ignored, no pop, pointers hold.
REQ-024 flush = 1 at an edge: pointers and count -> 0, datapath_ready -> 1, push and pop in that cycle discarded; flush has priority.
REQ-025 fill_level = count.

Reset
REQ-026 resetN low: count 0, pointers 0, color_out_valid 0, color_out MIN_COLOR, datapath_ready 1, fill_level 0.
REQ-027 Reset mid-operation discards all stored pixels; memory array not reset.
REQ-028 First push possible at first edge after resetN release.

Configuration
REQ-029 Macro PIXEL_SINK_STATS_EN defined: extra output pix_count [15:0] = number of pops since reset/flush, wraps 65535 -> 0.
REQ-030 PIXEL_SINK_STATS_EN undefined: pix_count port and counter absent; all other behaviour identical.

Verification
REQ-031 DEPTH=4, out_ready=1, push 0x10 -> color_out=0x10, valid=1 one cycle later, fill_level returns to 0 after pop.
REQ-032 out_ready=0, push 0x01..0x04 -> fill_level=4, datapath_ready=0; color_in_valid held with 0x05 -> not captured.
REQ-033 Full, out_ready=1 one cycle -> 0x01 popped, datapath_ready=1 next cycle, 0x05 pushed once; drain order 0x02..0x05.
REQ-034 count=2, push and pop same edge -> fill_level stays 2, order preserved.
REQ-035 count=3, flush=1 with push and pop -> fill_level=0, valid=0, color_out=MIN_COLOR, datapath_ready=1.
REQ-036 resetN low mid-stream at count=3 -> all outputs at reset values; with PIXEL_SINK_STATS_EN, 65537 pops -> pix_count=1.
